// File: rtl/native_mem_pkg.sv
// Shared types and address-window helpers for the native-interface memory slave.
package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wide enough for the largest supported wait-state count (15).
  localparam int WCNT_W = 4;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // One past the last byte of the window; 33 bits so a window ending at 4 GiB still compares correctly.
  function automatic logic [32:0] window_end(input logic [31:0] base, input int words);
    return {1'b0, base} + (33'(words) << 2);
  endfunction

endpackage

// File: rtl/native_mem_array.sv
// WORDS x 32 storage with a registered read port and a byte-enable write port.
module native_mem_array #(
  parameter int WORDS = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data
);
  import native_mem_pkg::*;

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/native_mem_slave.sv
// picorv32 native-bus memory slave: window decode, wait-state handshake, sticky range error, access counters.
module native_mem_slave #(
  parameter int          WORDS       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic             oor_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);
  import native_mem_pkg::*;

  localparam int                IDX_W     = idx_w(WORDS);
  localparam logic [32:0]       WIN_END   = window_end(BASE_ADDR, WORDS);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_range_q, in_range_d;
  logic              is_write_q, is_write_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              oor_q, oor_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [31:0]       rdata_hold_q, rdata_hold_d;

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_in_range;
  logic              dec_is_write;
  logic              rd_en;
  logic              wr_en;
  logic              done;
  logic [31:0]       arr_rdata;
  logic [31:0]       fresh_rdata;

  always_comb begin
    dec_idx      = IDX_W'((mem_addr - BASE_ADDR) >> 2);
    dec_in_range = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < WIN_END);
    dec_is_write = (|mem_wstrb) && !mem_instr;
    fresh_rdata  = in_range_q ? arr_rdata : OOR_RDATA;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    in_range_d   = in_range_q;
    is_write_d   = is_write_q;
    wcnt_d       = wcnt_q;
    oor_d        = oor_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    rdata_hold_d = rdata_hold_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          idx_d      = dec_idx;
          in_range_d = dec_in_range;
          is_write_d = dec_is_write;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            rd_en   = !dec_is_write && dec_in_range;
          end else begin
            wcnt_d  = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A master that withdraws its request mid-wait abandons the access entirely.
        if (!mem_valid) begin
          state_d = IDLE;
        end else if (wcnt_q == '0) begin
          state_d = RESP;
          rd_en   = !is_write_q && in_range_q;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        done    = mem_valid;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      wr_en = is_write_q && in_range_q && !reset;
      if (!in_range_q) oor_d = 1'b1;
      if (is_write_q) begin
        if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        rdata_hold_d = fresh_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      oor_q        <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      oor_q        <= oor_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Transaction attributes are only meaningful outside IDLE, so they carry no reset.
  always_ff @(posedge clk) begin
    idx_q      <= idx_d;
    in_range_q <= in_range_d;
    is_write_q <= is_write_d;
    wcnt_q     <= wcnt_d;
  end

  native_mem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (idx_d),
    .rd_data (arr_rdata),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_strb (mem_wstrb),
    .wr_data (mem_wdata)
  );

  assign mem_ready = (state_q == RESP) && mem_valid;
  assign mem_rdata = ((state_q == RESP) && !is_write_q) ? fresh_rdata : rdata_hold_q;
  assign oor_err   = oor_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_native_mem_slave.sv
// Bench for native_mem_slave: three instances (0, 3 and 4 wait states) driven through scenario tasks.
module tb_native_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        mem_valid [3];
  logic        mem_instr [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_wstrb [3];

  logic        rdy0, rdy1, rdy2;
  logic        oor0, oor1, oor2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [15:0] rdc0, wrc0, rdc2, wrc2;
  logic [3:0]  rdc1, wrc1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];

  native_mem_slave #(.WAIT_STATES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst[0]), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_ready(rdy0), .mem_rdata(rdata0), .oor_err(oor0), .rd_count(rdc0), .wr_count(wrc0));

  native_mem_slave #(.WAIT_STATES(3), .CNT_W(4)) dut1 (
    .clk(clk), .reset(rst[1]), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_ready(rdy1), .mem_rdata(rdata1), .oor_err(oor1), .rd_count(rdc1), .wr_count(wrc1));

  native_mem_slave #(.WAIT_STATES(4), .CNT_W(16)) dut2 (
    .clk(clk), .reset(rst[2]), .mem_valid(mem_valid[2]), .mem_instr(mem_instr[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_wstrb(mem_wstrb[2]),
    .mem_ready(rdy2), .mem_rdata(rdata2), .oor_err(oor2), .rd_count(rdc2), .wr_count(wrc2));

  function automatic logic get_rdy(input int k);
    return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic [31:0] get_rdata(input int k);
    return (k == 0) ? rdata0 : (k == 1) ? rdata1 : rdata2;
  endfunction
  function automatic logic get_oor(input int k);
    return (k == 0) ? oor0 : (k == 1) ? oor1 : oor2;
  endfunction
  function automatic logic [15:0] get_rdc(input int k);
    return (k == 0) ? rdc0 : (k == 1) ? {12'b0, rdc1} : rdc2;
  endfunction
  function automatic logic [15:0] get_wrc(input int k);
    return (k == 0) ? wrc0 : (k == 1) ? {12'b0, wrc1} : wrc2;
  endfunction

  // Drives one request from just after a rising edge and holds it through the completion edge.
  task automatic xfer(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic instr, output int lat,
                      output logic [31:0] rdata, output logic rdy_after, output bit got);
    mem_valid[k] = 1'b1;
    mem_instr[k] = instr;
    mem_addr[k]  = addr;
    mem_wdata[k] = wdata;
    mem_wstrb[k] = strb;
    got = 1'b0; lat = 0; rdata = '0; rdy_after = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (get_rdy(k)) begin
        got = 1'b1; lat = c; rdata = get_rdata(k);
      end
    end
    if (got) begin
      @(posedge clk); #1;
      rdy_after = get_rdy(k);
    end
    mem_valid[k] = 1'b0;
    mem_instr[k] = 1'b0;
    mem_wstrb[k] = 4'h0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests += 5;
      if (get_rdy(k) !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0", k, get_rdy(k)); end
      if (get_rdata(k) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, get_rdata(k)); end
      if (get_oor(k) !== 1'b0) begin n_fail++; $display("FAIL reset_oor[%0d]: got %b want 0", k, get_oor(k)); end
      if (get_rdc(k) !== 16'h0) begin n_fail++; $display("FAIL reset_rdc[%0d]: got %0d want 0", k, get_rdc(k)); end
      if (get_wrc(k) !== 16'h0) begin n_fail++; $display("FAIL reset_wrc[%0d]: got %0d want 0", k, get_wrc(k)); end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    xfer(0, 32'h08, 32'h1234_5678, 4'hF, 1'b0, lat, rd, ra, got);
    n_tests += 2;
    if (!got || lat != 1) begin n_fail++; $display("FAIL wr_latency: got %0d (seen %0d) want 1", lat, got); end
    if (ra !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width: ready after pulse %b want 0", ra); end
    sb.push_back(32'h1234_5678);
    xfer(0, 32'h08, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 5;
    if (!got || lat != 1) begin n_fail++; $display("FAIL rd_latency: got %0d (seen %0d) want 1", lat, got); end
    if (ra !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_width: ready after pulse %b want 0", ra); end
    if (rd !== exp) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd, exp); end
    if (wrc0 !== 16'd1) begin n_fail++; $display("FAIL wr_count_1: got %0d want 1", wrc0); end
    if (rdc0 !== 16'd1) begin n_fail++; $display("FAIL rd_count_1: got %0d want 1", rdc0); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    xfer(1, 32'h04, 32'hCAFE_F00D, 4'hF, 1'b0, lat, rd, ra, got);
    n_tests += 1;
    if (!got || lat != 4) begin n_fail++; $display("FAIL ws3_wr_latency: got %0d want 4", lat); end
    sb.push_back(32'hCAFE_F00D);
    xfer(1, 32'h04, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 3;
    if (!got || lat != 4) begin n_fail++; $display("FAIL ws3_rd_latency: got %0d want 4", lat); end
    if (rd !== exp) begin n_fail++; $display("FAIL ws3_rd_data: got %h want %h", rd, exp); end
    if (ra !== 1'b0) begin n_fail++; $display("FAIL ws3_pulse_width: ready after pulse %b want 0", ra); end
  endtask

  task automatic test_byte_strobes();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    xfer(0, 32'h00, 32'hAABB_CCDD, 4'hF, 1'b0, lat, rd, ra, got);
    xfer(0, 32'h00, 32'h1122_3344, 4'b0101, 1'b0, lat, rd, ra, got);
    sb.push_back(32'hAA22_CC44);
    xfer(0, 32'h00, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 1;
    if (!got || rd !== exp) begin n_fail++; $display("FAIL strobe_merge: got %h want %h", rd, exp); end
    xfer(0, 32'h14, 32'h7777_7777, 4'hF, 1'b0, lat, rd, ra, got);
    n_tests += 1;
    if (rdata0 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL rdata_hold: got %h want aa22cc44", rdata0); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    n_tests += 1;
    if (oor0 !== 1'b0) begin n_fail++; $display("FAIL oor_before: got %b want 0", oor0); end
    sb.push_back(32'hDEAD_BEEF);
    xfer(0, 32'h80, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 3;
    if (!got || lat != 1) begin n_fail++; $display("FAIL oor_rd_latency: got %0d want 1", lat); end
    if (rd !== exp) begin n_fail++; $display("FAIL oor_rdata: got %h want %h", rd, exp); end
    if (oor0 !== 1'b1) begin n_fail++; $display("FAIL oor_set: got %b want 1", oor0); end
    xfer(0, 32'h80, 32'h5555_5555, 4'hF, 1'b0, lat, rd, ra, got);
    sb.push_back(32'hAA22_CC44);
    xfer(0, 32'h00, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 2;
    if (rd !== exp) begin n_fail++; $display("FAIL oor_write_dropped: word0 %h want %h", rd, exp); end
    if (oor0 !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b want 1", oor0); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    xfer(0, 32'h10, 32'h0BAD_C0DE, 4'hF, 1'b0, lat, rd, ra, got);
    sb.push_back(32'h0BAD_C0DE);
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b1, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 4;
    if (!got || lat != 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    if (rd !== exp) begin n_fail++; $display("FAIL b2b_raw_data: got %h want %h", rd, exp); end
    if (wrc0 !== 16'd6) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 6", wrc0); end
    if (rdc0 !== 16'd5) begin n_fail++; $display("FAIL b2b_rd_count: got %0d want 5", rdc0); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    xfer(2, 32'h0C, 32'hA5A5_A5A5, 4'hF, 1'b0, lat, rd, ra, got);
    n_tests += 1;
    if (!got || lat != 5) begin n_fail++; $display("FAIL ws4_wr_latency: got %0d want 5", lat); end
    mem_valid[2] = 1'b1; mem_addr[2] = 32'h0C; mem_wdata[2] = 32'hFFFF_FFFF; mem_wstrb[2] = 4'hF;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    n_tests += 3;
    if (rdy2 !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", rdy2); end
    if (wrc2 !== 16'd0) begin n_fail++; $display("FAIL abort_wr_count: got %0d want 0", wrc2); end
    if (rdc2 !== 16'd0) begin n_fail++; $display("FAIL abort_rd_count: got %0d want 0", rdc2); end
    rst[2] = 1'b0;
    sb.push_back(32'hA5A5_A5A5);
    xfer(2, 32'h0C, 32'h0, 4'h0, 1'b0, lat, rd, ra, got);
    exp = sb.pop_front();
    n_tests += 4;
    if (!got || lat != 5) begin n_fail++; $display("FAIL abort_idle_latency: got %0d want 5", lat); end
    if (rd !== exp) begin n_fail++; $display("FAIL abort_word_kept: got %h want %h", rd, exp); end
    if (rdc2 !== 16'd1) begin n_fail++; $display("FAIL abort_rd_after: got %0d want 1", rdc2); end
    if (wrc2 !== 16'd0) begin n_fail++; $display("FAIL abort_wr_after: got %0d want 0", wrc2); end
  endtask

  task automatic test_saturation();
    int lat; logic [31:0] rd, exp; logic ra; bit got;
    mem_valid[1] = 1'b1; mem_addr[1] = 32'h04; mem_wstrb[1] = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid[1] = 1'b0;
    @(posedge clk); #1;
    n_tests += 2;
    if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", rdy1); end
    if (rdc1 !== 4'd1) begin n_fail++; $display("FAIL drop_no_count: got %0d want 1", rdc1); end
    for (int i = 0; i < 20; i++) begin
      sb.push_back(32'hCAFE_F00D);
      xfer(1, 32'h04, 32'h0, 4'h0, i[0], lat, rd, ra, got);
      exp = sb.pop_front();
      n_tests += 1;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL sat_rd_data[%0d]: got %h want %h", i, rd, exp); end
      if (i == 0) begin
        n_tests += 1;
        if (lat != 4) begin n_fail++; $display("FAIL drop_then_idle_latency: got %0d want 4", lat); end
      end
    end
    n_tests += 2;
    if (rdc1 !== 4'd15) begin n_fail++; $display("FAIL rd_count_sat: got %0d want 15", rdc1); end
    if (wrc1 !== 4'd1) begin n_fail++; $display("FAIL wr_count_ws3: got %0d want 1", wrc1); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; mem_valid[k] = 1'b0; mem_instr[k] = 1'b0;
      mem_addr[k] = '0; mem_wdata[k] = '0; mem_wstrb[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_byte_strobes();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/native_mem_slave.md
Name: native_mem_slave

Overview:
- Parametrised single-port word memory serving the picorv32 native memory interface.
- Successor to the fixed always-ready SoC memory: generates a real mem_ready handshake with configurable wait states.
- Decodes a base-address window, flags out-of-range accesses, and counts completed reads and writes.
- Sits directly on the CPU's mem_* bus in design_top, replacing the hard-wired mem_ready.

Parameters:
- WORDS, 32: memory depth in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to 4*WORDS.
- WAIT_STATES, 0: extra cycles inserted between request acceptance and mem_ready; range 0..15.
- OOR_RDATA, 32'hDEAD_BEEF: read data returned for out-of-range reads.
- CNT_W, 16: width of the access counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  CPU request valid; held until mem_ready.
- mem_instr  in  1  instruction fetch qualifier; counted as a read, otherwise ignored.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid only while mem_ready=1.
- oor_err  out  1  sticky out-of-range flag.
- rd_count  out  CNT_W  completed reads, saturating.
- wr_count  out  CNT_W  completed writes, saturating.

Behaviour:
- Reset (synchronous, active-high, clk):
  - mem_ready=0, mem_rdata=0, oor_err=0, rd_count=0, wr_count=0, state=IDLE.
  - Memory array contents are not cleared.
  - Reset asserted mid-transaction aborts it: no write, no pulse, IDLE on the next cycle.
- Address decode:
  - idx = (mem_addr - BASE_ADDR) >> 2, truncated to $clog2(WORDS) bits.
  - in_range = mem_addr in [BASE_ADDR, BASE_ADDR + 4*WORDS).
- FSM states IDLE, WAIT, RESP:
  - IDLE: when mem_valid=1, latch idx, in_range and is_write = |mem_wstrb.
    - WAIT_STATES=0: go to RESP.
    - Otherwise: load wait counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then IDLE.
- Timing:
  - Request first seen in IDLE at cycle N gives mem_ready=1 at cycle N+1+WAIT_STATES.
  - Back-to-back requests: mem_valid seen in IDLE at N+2+WAIT_STATES starts a new transaction immediately.
- Read:
  - Array read is registered on the cycle entering RESP.
  - mem_rdata = in_range ? mem[idx] : OOR_RDATA.
  - mem_rdata holds its value after the pulse until the next read completes.
- Write:
  - Committed on the RESP cycle, byte lanes per mem_wstrb, only if in_range.
  - mem_rdata is not updated by writes.
- Out-of-range access: completes normally (mem_ready pulses), write dropped, oor_err set and held until reset.
- Protocol violation: mem_valid dropping while in WAIT or RESP aborts to IDLE with no write, no mem_ready and no count.
- Counters:
  - rd_count increments on RESP of a read; wr_count on RESP of a write; out-of-range accesses included.
  - Both saturate at 2^CNT_W-1.
- Write strobe patterns: any pattern is legal, e.g. 4'b0101.
- Read-after-write to the same word: the next transaction returns the new data.

Decomposition:
- Package native_mem_pkg: state enum (IDLE, WAIT, RESP), wait-counter width constant, localparams IDX_W=$clog2(WORDS) and the window end address.
- One sub-module, native_mem_array: WORDS x 32 synchronous array with a registered read port and byte-enable write port.
- The FSM, decode and counters stay in native_mem_slave.

Test Plan:
- WAIT_STATES=0, write 32'h1234_5678, wstrb 4'hF to 0x08, then read 0x08 -> mem_ready exactly 1 cycle after each request; read returns 32'h1234_5678; wr_count=1, rd_count=1.
- WAIT_STATES=3, read 0x04 with valid asserted at cycle 10 -> mem_ready=1 only at cycle 14; mem_rdata correct at 14.
- Word 0x0 = 32'hAABB_CCDD, write 32'h1122_3344 with wstrb 4'b0101 -> read gives 32'hAA22_CC44.
- Read 0x80 with WORDS=32, BASE=0 -> mem_rdata=32'hDEAD_BEEF, oor_err=1 and sticky; a write to 0x80 leaves the array unchanged.
- WAIT_STATES=4, reset pulsed at cycle 2 of a write to 0x0C -> no mem_ready, word 0x0C unchanged, counters 0, IDLE next cycle.
- CNT_W=4, 20 reads -> rd_count saturates at 15; mem_valid dropped during WAIT -> no pulse, no count.
